// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths, opcode constants and fetch-state encoding for
//               the 8-bit multicycle CPU.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_field_split.sv
`default_nettype none
// ============================================================================
// Module      : instr_field_split
// Description : Purely combinational split of an instruction word into its
//               op / rs / rt / imm(rd) fields. Shared with decode.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_field_split
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output logic [1:0]         o_op,
  output logic [1:0]         o_rs,
  output logic [1:0]         o_rt,
  output logic [1:0]         o_imm
);

  // Fixed field positions: op[7:6] rs[5:4] rt[3:2] imm/rd[1:0]
  always_comb begin
    o_op  = i_instr[7:6];
    o_rs  = i_instr[5:4];
    o_rt  = i_instr[3:2];
    o_imm = i_instr[1:0];
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetch stage. Holds the PC, issues req/ack reads to instruction
//               memory, latches the returned word into the instruction
//               register and hands it to decode with valid/ready. Accepts
//               redirects from execute, including while a read is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               halt,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [1:0]         out_op,
  output logic [1:0]         out_rs,
  output logic [1:0]         out_rt,
  output logic [1:0]         out_imm
);
  import cpu_pkg::*;

  fetch_state_t       r_state, w_state_nxt;
  logic [PC_W-1:0]    r_pc, w_pc_nxt;
  logic [PC_W-1:0]    r_req_addr, w_req_addr_nxt;
  logic               r_drop, w_drop_nxt;
  logic [INSTR_W-1:0] r_out_instr, w_out_instr_nxt;
  logic [PC_W-1:0]    r_out_pc, w_out_pc_nxt;

  // State and datapath registers; reset is asynchronous so imem_req and
  // out_valid (both decoded from state) fall immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_req_addr  <= '0;
      r_drop      <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_req_addr  <= w_req_addr_nxt;
      r_drop      <= w_drop_nxt;
      r_out_instr <= w_out_instr_nxt;
      r_out_pc    <= w_out_pc_nxt;
    end
  end

  // Next-state and next-datapath decision; everything holds by default
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_req_addr_nxt  = r_req_addr;
    w_drop_nxt      = r_drop;
    w_out_instr_nxt = r_out_instr;
    w_out_pc_nxt    = r_out_pc;
    case (r_state)
      IDLE: begin
        if (redirect) begin
          w_pc_nxt = redirect_pc;
        end
        if (!halt) begin
          w_state_nxt    = FETCH;
          // A same-cycle redirect must steer this very fetch
          w_req_addr_nxt = redirect ? redirect_pc : r_pc;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            // Returned word belongs to the old path: drop it, restart at target
            w_pc_nxt       = redirect_pc;
            w_req_addr_nxt = redirect_pc;
            w_drop_nxt     = 1'b0;
          end else if (r_drop) begin
            // Completion of a request orphaned by an earlier redirect
            w_drop_nxt     = 1'b0;
            w_req_addr_nxt = r_pc;
          end else begin
            w_out_instr_nxt = imem_rdata;
            w_out_pc_nxt    = r_req_addr;
            w_pc_nxt        = r_req_addr + PC_W'(1);
            w_state_nxt     = HOLD;
          end
        end else if (redirect) begin
          // Request in flight cannot be withdrawn; remember to discard it
          w_pc_nxt   = redirect_pc;
          w_drop_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          // Squash the held instruction even if decode accepts it this cycle
          w_pc_nxt       = redirect_pc;
          w_req_addr_nxt = redirect_pc;
          w_state_nxt    = halt ? IDLE : FETCH;
        end else if (out_ready) begin
          w_req_addr_nxt = r_pc;
          w_state_nxt    = halt ? IDLE : FETCH;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Handshake outputs decoded straight from registered state
  always_comb begin
    imem_req  = (r_state == FETCH);
    imem_addr = r_req_addr;
    out_valid = (r_state == HOLD);
    out_instr = r_out_instr;
    out_pc    = r_out_pc;
  end

  instr_field_split u_split (
    .i_instr (r_out_instr),
    .o_op    (out_op),
    .o_rs    (out_rs),
    .o_rt    (out_rt),
    .o_imm   (out_imm)
  );

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch with a
//               variable-latency instruction memory model, plus a second
//               instance started at PC 8'hFE to observe address wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
  import cpu_pkg::*;

  logic       clk;
  logic       reset;
  logic       halt;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       imem_ack;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_instr;
  logic [7:0] out_pc;
  logic [1:0] out_op, out_rs, out_rt, out_imm;

  logic       fe_req;
  logic [7:0] fe_addr;
  logic       fe_valid;
  logic [7:0] fe_instr;
  logic [7:0] fe_pc;
  logic [1:0] fe_op, fe_rs, fe_rt, fe_imm;

  int         mem_lat;
  int         mcnt;
  int         n_tests;
  int         n_fail;
  int         cyc;
  logic [7:0] fe_seen [4];
  int         fe_n;

  // Memory contents: two fixed words at 0/1, everything else addr ^ A5
  function automatic logic [7:0] mem_model(input logic [7:0] a);
    if (a == 8'h00) return 8'h41;
    if (a == 8'h01) return 8'hC3;
    return a ^ 8'hA5;
  endfunction

  instr_fetch u_dut (
    .clk         (clk),
    .reset       (reset),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_op      (out_op),
    .out_rs      (out_rs),
    .out_rt      (out_rt),
    .out_imm     (out_imm)
  );

  instr_fetch #(.RESET_PC(8'hFE)) u_dut_fe (
    .clk         (clk),
    .reset       (reset),
    .halt        (1'b0),
    .imem_req    (fe_req),
    .imem_addr   (fe_addr),
    .imem_rdata  (mem_model(fe_addr)),
    .imem_ack    (fe_req),
    .redirect    (1'b0),
    .redirect_pc (8'h00),
    .out_valid   (fe_valid),
    .out_ready   (1'b1),
    .out_instr   (fe_instr),
    .out_pc      (fe_pc),
    .out_op      (fe_op),
    .out_rs      (fe_rs),
    .out_rt      (fe_rt),
    .out_imm     (fe_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = mem_model(imem_addr);
  assign imem_ack   = imem_req && (mcnt == mem_lat);

  // Cycles the current request has been outstanding
  always @(posedge clk or posedge reset) begin
    if (reset) mcnt <= 0;
    else if (!imem_req || imem_ack) mcnt <= 0;
    else mcnt <= mcnt + 1;
  end

  // Record the first four instructions handed out by the wrap instance
  always @(posedge clk) begin
    #1;
    if (!reset && fe_valid && fe_n < 4) begin
      fe_seen[fe_n] = fe_pc;
      fe_n = fe_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until out_valid, checking the request stays put; returns cycles
  task automatic wait_valid(input string tag, input logic [7:0] addr, output int n);
    n = 0;
    while (!out_valid && n < 12) begin
      check({tag, "_req"}, imem_req, 1);
      check({tag, "_addr"}, imem_addr, addr);
      tick();
      n = n + 1;
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; fe_n = 0;
    reset = 1'b1; halt = 1'b0; out_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 8'h00; mem_lat = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",   imem_req,  0);
    check("rst_valid", out_valid, 0);
    check("rst_instr", out_instr, 0);
    check("rst_pc",    out_pc,    0);
    reset = 1'b0;

    // 0-wait memory, decode always ready: one instruction every 2 cycles
    tick();
    check("t1_req",    imem_req,  1);
    check("t1_addr",   imem_addr, 8'h00);
    check("t1_valid0", out_valid, 0);
    tick();
    check("t1_valid1", out_valid, 1);
    check("t1_instr1", out_instr, 8'h41);
    check("t1_pc1",    out_pc,    8'h00);
    check("t1_op1",    out_op,    2'b01);
    check("t1_imm1",   out_imm,   2'b01);
    tick();
    check("t1_gap",    out_valid, 0);
    check("t1_addr2",  imem_addr, 8'h01);
    tick();
    check("t1_valid2", out_valid, 1);
    check("t1_instr2", out_instr, 8'hC3);
    check("t1_pc2",    out_pc,    8'h01);
    check("t1_op2",    out_op,    OP_J);
    check("t1_rs2",    out_rs,    2'b00);
    check("t1_rt2",    out_rt,    2'b00);
    check("t1_imm2",   out_imm,   2'b11);

    // Decode stalls 5 cycles, then a 3-cycle-latency fetch
    out_ready = 1'b0; mem_lat = 3;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_valid", out_valid, 1);
      check("t2_instr", out_instr, 8'hC3);
      check("t2_pc",    out_pc,    8'h01);
      check("t2_req",   imem_req,  0);
    end
    out_ready = 1'b1;
    tick();
    wait_valid("t2", 8'h02, cyc);
    check("t2_lat",   cyc,       4);
    check("t2_instr", out_instr, 8'hA7);
    check("t2_pc",    out_pc,    8'h02);

    // Redirect to 20 while the fetch of 03 is two cycles from its ack
    tick();
    check("t4_addr3", imem_addr, 8'h03);
    tick();
    redirect = 1'b1; redirect_pc = 8'h20;
    tick();
    redirect = 1'b0;
    check("t4_keep_req",  imem_req,  1);
    check("t4_keep_addr", imem_addr, 8'h03);
    tick();
    check("t4_ack_addr",  imem_addr, 8'h03);
    check("t4_ack_valid", out_valid, 0);
    tick();
    check("t4_drop_valid", out_valid, 0);
    wait_valid("t4", 8'h20, cyc);
    check("t4_lat",   cyc,       4);
    check("t4_pc",    out_pc,    8'h20);
    check("t4_instr", out_instr, 8'h85);

    // Redirect to 10 in HOLD with out_ready high: squash wins
    redirect = 1'b1; redirect_pc = 8'h10; mem_lat = 0;
    tick();
    redirect = 1'b0;
    check("t5_valid", out_valid, 0);
    check("t5_req",   imem_req,  1);
    check("t5_addr",  imem_addr, 8'h10);
    tick();
    check("t5_valid1", out_valid, 1);
    check("t5_pc",     out_pc,    8'h10);
    check("t5_instr",  out_instr, 8'hB5);
    mem_lat = 2;
    tick();
    check("t5_next_addr", imem_addr, 8'h11);

    // Halt during an outstanding fetch: it completes, then IDLE
    halt = 1'b1;
    tick();
    check("t6_req_kept", imem_req, 1);
    tick();
    tick();
    check("t6_valid", out_valid, 1);
    check("t6_pc",    out_pc,    8'h11);
    check("t6_instr", out_instr, 8'hB4);
    tick();
    check("t6_idle_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_idle_req", imem_req, 0);
    end
    halt = 1'b0;
    tick();
    check("t6_req",       imem_req,  1);
    check("t6_addr",      imem_addr, 8'h12);
    check("t6_instr_old", out_instr, 8'hB4);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_req",   imem_req,  0);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_instr", out_instr, 0);
    check("t6_rst_pc",    out_pc,    0);

    // PC wrap observed on the second instance
    check("fe_count", fe_n, 4);
    check("fe_pc0", fe_seen[0], 8'hFE);
    check("fe_pc1", fe_seen[1], 8'hFF);
    check("fe_pc2", fe_seen[2], 8'h00);
    check("fe_pc3", fe_seen[3], 8'h01);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
